// File: rtl/ex_mem_if.sv
// EX/MEM bus: Execute-side inputs, Memory-side outputs and status.
interface ex_mem_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              ivalid;
  logic              oready;
  logic [DATA_W-1:0] iadder_branch_result;
  logic              iALU_zero;
  logic [DATA_W-1:0] iALU_result;
  logic [DATA_W-1:0] iregfile_read_2;
  logic [REG_W-1:0]  ireg_write_reg;
  logic              iSig_Branch;
  logic              iSig_MemRead;
  logic              iSig_MemWrite;
  logic              iSig_RegWrite;
  logic              iSig_MemtoReg;
  logic              ovalid;
  logic              iready;
  logic [DATA_W-1:0] o_adder_branch_result;
  logic              oALU_zero;
  logic [DATA_W-1:0] oALU_result;
  logic [DATA_W-1:0] oregfile_read_2;
  logic [REG_W-1:0]  oreg_write_reg;
  logic              oSig_Branch;
  logic              oSig_MemRead;
  logic              oSig_MemWrite;
  logic              oSig_RegWrite;
  logic              oSig_MemtoReg;
  logic              oPCSrc;
  logic [CNT_W-1:0]  ostall_cnt;

  // Pipeline register view.
  modport slave (
    input  ivalid, iadder_branch_result, iALU_zero, iALU_result, iregfile_read_2,
           ireg_write_reg, iSig_Branch, iSig_MemRead, iSig_MemWrite, iSig_RegWrite,
           iSig_MemtoReg, iready,
    output oready, ovalid, o_adder_branch_result, oALU_zero, oALU_result, oregfile_read_2,
           oreg_write_reg, oSig_Branch, oSig_MemRead, oSig_MemWrite, oSig_RegWrite,
           oSig_MemtoReg, oPCSrc, ostall_cnt
  );

  // Surrounding pipeline view (Execute producer and Memory consumer).
  modport master (
    output ivalid, iadder_branch_result, iALU_zero, iALU_result, iregfile_read_2,
           ireg_write_reg, iSig_Branch, iSig_MemRead, iSig_MemWrite, iSig_RegWrite,
           iSig_MemtoReg, iready,
    input  oready, ovalid, o_adder_branch_result, oALU_zero, oALU_result, oregfile_read_2,
           oreg_write_reg, oSig_Branch, oSig_MemRead, oSig_MemWrite, oSig_RegWrite,
           oSig_MemtoReg, oPCSrc, ostall_cnt
  );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with a 2-entry skid buffer, branch-taken select
// and a saturating stall-cycle counter.
module ex_mem_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     iflush,
  ex_mem_if.slave  bus
);

  typedef struct packed {
    logic [DATA_W-1:0] br_tgt;
    logic              zero;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rd2;
    logic [REG_W-1:0]  rd;
    logic              branch;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
  } payload_t;

  payload_t         main_q, main_d, skid_q, skid_d, in_pl;
  logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, load;

  // Pack the Execute outputs into one payload word.
  always_comb begin
    in_pl = '{
      br_tgt:     bus.iadder_branch_result,
      zero:       bus.iALU_zero,
      alu:        bus.iALU_result,
      rd2:        bus.iregfile_read_2,
      rd:         bus.ireg_write_reg,
      branch:     bus.iSig_Branch,
      mem_read:   bus.iSig_MemRead,
      mem_write:  bus.iSig_MemWrite,
      reg_write:  bus.iSig_RegWrite,
      mem_to_reg: bus.iSig_MemtoReg
    };
  end

  assign accept = bus.ivalid & ~skid_vld_q;
  assign load   = ~main_vld_q | bus.iready;

  // Next-state for main/skid entries; skid always drains before new input.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (iflush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (load) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = in_pl;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      // Main is stalled: park the new entry in the skid.
      skid_d     = in_pl;
      skid_vld_d = 1'b1;
    end
  end

  // Stall counter saturates at all-ones; iflush does not touch it.
  always_comb begin
    cnt_d = cnt_q;
    if (main_vld_q && !bus.iready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.oready                = ~skid_vld_q;
  assign bus.ovalid                = main_vld_q;
  assign bus.o_adder_branch_result = main_q.br_tgt;
  assign bus.oALU_zero             = main_q.zero;
  assign bus.oALU_result           = main_q.alu;
  assign bus.oregfile_read_2       = main_q.rd2;
  assign bus.oreg_write_reg        = main_q.rd;
  assign bus.oSig_Branch           = main_q.branch;
  assign bus.oSig_MemRead          = main_q.mem_read;
  assign bus.oSig_MemWrite         = main_q.mem_write;
  assign bus.oSig_RegWrite         = main_q.reg_write;
  assign bus.oSig_MemtoReg         = main_q.mem_to_reg;
  // Gated by valid so a stale held entry never redirects the PC.
  assign bus.oPCSrc                = main_vld_q & main_q.branch & main_q.zero;
  assign bus.ostall_cnt            = cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: vector table plus hand sequences, checked against an
// in-order occupancy model (queue of expected entries, max depth 2).
module tb_ex_mem_pipe;

  logic clk = 1'b0;
  logic reset;
  logic iflush;

  ex_mem_if #(.DATA_W(32), .REG_W(5), .CNT_W(16)) bus ();

  ex_mem_pipe #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .iflush (iflush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] tgt;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  rd;
    logic        br;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        m2r;
  } pl_t;

  typedef struct {
    logic        v;
    logic        r;
    logic [31:0] alu;
    logic        br;
    logic        z;
    logic [31:0] tgt;
    logic        fl;
    logic        e_ov;
    logic        e_or;
  } vec_t;

  pl_t         sb[$];
  logic [15:0] cnt_m;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic pl_t make_pl(logic [31:0] alu, logic br, logic z, logic [31:0] tgt);
    pl_t p;
    p.tgt  = tgt;
    p.zero = z;
    p.alu  = alu;
    p.rd2  = ~alu;
    p.rd   = alu[4:0] ^ 5'h15;
    p.br   = br;
    p.mr   = alu[0];
    p.mw   = alu[1];
    p.rw   = alu[2];
    p.m2r  = alu[3];
    return p;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic pl_t dut_pl();
    pl_t p;
    p = {bus.o_adder_branch_result, bus.oALU_zero, bus.oALU_result, bus.oregfile_read_2,
         bus.oreg_write_reg, bus.oSig_Branch, bus.oSig_MemRead, bus.oSig_MemWrite,
         bus.oSig_RegWrite, bus.oSig_MemtoReg};
    return p;
  endfunction

  // Compare DUT outputs with the model state, away from the rising edge.
  task automatic sample();
    @(negedge clk);
    chk("ovalid", 128'(bus.ovalid), 128'(sb.size() > 0));
    chk("oready", 128'(bus.oready), 128'(sb.size() < 2));
    chk("stall_cnt", 128'(bus.ostall_cnt), 128'(cnt_m));
    if (sb.size() > 0) begin
      chk("payload", 128'(dut_pl()), 128'(sb[0]));
      chk("oPCSrc", 128'(bus.oPCSrc), 128'(sb[0].br & sb[0].zero));
    end
  endtask

  // Drive one cycle of stimulus and advance the model across the next edge.
  task automatic drive(input logic v, input logic r, input logic [31:0] alu, input logic br,
                       input logic z, input logic [31:0] tgt, input logic fl);
    pl_t p;
    bit  drain, acc;
    p = make_pl(alu, br, z, tgt);
    bus.ivalid               = v;
    bus.iready               = r;
    bus.iadder_branch_result = p.tgt;
    bus.iALU_zero            = p.zero;
    bus.iALU_result          = p.alu;
    bus.iregfile_read_2      = p.rd2;
    bus.ireg_write_reg       = p.rd;
    bus.iSig_Branch          = p.br;
    bus.iSig_MemRead         = p.mr;
    bus.iSig_MemWrite        = p.mw;
    bus.iSig_RegWrite        = p.rw;
    bus.iSig_MemtoReg        = p.m2r;
    iflush                   = fl;
    drain = (sb.size() > 0) && r;
    acc   = v && (sb.size() < 2);
    if ((sb.size() > 0) && !r && (cnt_m != 16'hFFFF)) cnt_m++;
    if (fl) begin
      sb.delete();
    end else begin
      if (drain) void'(sb.pop_front());
      if (acc) sb.push_back(p);
    end
    @(posedge clk);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset     = 1'b1;
    iflush    = 1'b0;
    bus.ivalid = 1'b0;
    bus.iready = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    chk("rst_ovalid", 128'(bus.ovalid), 128'(0));
    chk("rst_oready", 128'(bus.oready), 128'(1));
    chk("rst_payload", 128'(dut_pl()), 128'(0));
    chk("rst_oPCSrc", 128'(bus.oPCSrc), 128'(0));
    chk("rst_cnt", 128'(bus.ostall_cnt), 128'(0));
    reset = 1'b0;
    sb.delete();
    cnt_m = '0;
  endtask

  vec_t vecs[21];

  initial begin
    // v r alu br z tgt fl | ovalid oready seen before this cycle's edge
    vecs[0]  = '{1, 1, 32'h10, 0, 0, 32'h0, 0, 0, 1};
    vecs[1]  = '{1, 1, 32'h20, 0, 1, 32'h0, 0, 1, 1};
    vecs[2]  = '{1, 1, 32'h30, 0, 0, 32'h0, 0, 1, 1};
    vecs[3]  = '{1, 1, 32'h40, 0, 1, 32'h0, 0, 1, 1};
    vecs[4]  = '{0, 1, 32'h0,  0, 0, 32'h0, 0, 1, 1};
    vecs[5]  = '{0, 1, 32'h0,  0, 0, 32'h0, 0, 0, 1};
    vecs[6]  = '{1, 1, 32'h11, 0, 0, 32'h0, 0, 0, 1};
    vecs[7]  = '{1, 0, 32'h22, 0, 0, 32'h0, 0, 1, 1};
    vecs[8]  = '{1, 0, 32'h33, 0, 0, 32'h0, 0, 1, 0};
    vecs[9]  = '{1, 1, 32'h33, 0, 0, 32'h0, 0, 1, 0};
    vecs[10] = '{1, 1, 32'h33, 0, 0, 32'h0, 0, 1, 1};
    vecs[11] = '{0, 1, 32'h0,  0, 0, 32'h0, 0, 1, 1};
    vecs[12] = '{0, 1, 32'h0,  0, 0, 32'h0, 0, 0, 1};
    vecs[13] = '{1, 1, 32'h50, 1, 1, 32'h00400020, 0, 0, 1};
    vecs[14] = '{1, 1, 32'h60, 1, 0, 32'h00400040, 0, 1, 1};
    vecs[15] = '{0, 1, 32'h0,  0, 0, 32'h0, 0, 1, 1};
    vecs[16] = '{0, 1, 32'h0,  0, 0, 32'h0, 0, 0, 1};
    vecs[17] = '{1, 0, 32'h71, 0, 0, 32'h0, 0, 0, 1};
    vecs[18] = '{1, 0, 32'h72, 0, 0, 32'h0, 0, 1, 1};
    vecs[19] = '{1, 1, 32'h73, 0, 0, 32'h0, 1, 1, 0};
    vecs[20] = '{0, 1, 32'h0,  0, 0, 32'h0, 0, 0, 1};

    reset = 1'b1;
    iflush = 1'b0;
    cnt_m = '0;
    bus.ivalid = 1'b0;
    bus.iready = 1'b1;
    do_reset(2);

    for (int i = 0; i < 21; i++) begin
      sample();
      chk($sformatf("vec%0d_ovalid", i), 128'(bus.ovalid), 128'(vecs[i].e_ov));
      chk($sformatf("vec%0d_oready", i), 128'(bus.oready), 128'(vecs[i].e_or));
      if (i == 14) chk("branch_taken", 128'(bus.oPCSrc), 128'(1));
      if (i == 14) chk("branch_tgt", 128'(bus.o_adder_branch_result), 128'(32'h00400020));
      if (i == 15) chk("branch_not_taken", 128'(bus.oPCSrc), 128'(0));
      if (i == 13) chk("stall_after_bp", 128'(bus.ostall_cnt), 128'(2));
      if (i == 20) chk("stall_after_flush", 128'(bus.ostall_cnt), 128'(3));
      drive(vecs[i].v, vecs[i].r, vecs[i].alu, vecs[i].br, vecs[i].z, vecs[i].tgt, vecs[i].fl);
    end

    // Flushed entry C (0x73) must never surface.
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("flush_no_c", 128'(bus.ovalid), 128'(0));
      drive(0, 1, 32'h0, 0, 0, 32'h0, 0);
    end

    // Saturation: one entry held under back-pressure past 2^16 cycles.
    sample();
    drive(1, 0, 32'h81, 0, 0, 32'h0, 0);
    for (int i = 0; i < 65540; i++) begin
      sample();
      drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
    end
    sample();
    chk("stall_saturated", 128'(bus.ostall_cnt), 128'(16'hFFFF));
    drive(1, 0, 32'h82, 0, 0, 32'h0, 0);
    sample();
    chk("full_before_reset", 128'(bus.oready), 128'(0));
    chk("sat_hold", 128'(bus.ostall_cnt), 128'(16'hFFFF));

    // Reset with both entries occupied clears everything in one cycle.
    do_reset(1);

    // Pipe still functional after reset: first entry is 0x91.
    sample();
    drive(1, 1, 32'h91, 1, 1, 32'h00400100, 0);
    sample();
    chk("post_rst_alu", 128'(bus.oALU_result), 128'(32'h91));
    drive(0, 1, 32'h0, 0, 0, 32'h0, 0);
    sample();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
